// File: rtl/tile_sequencer.sv
// Purpose: job-level controller that takes an N-tile job over valid/ready and
//          drives a per-tile engine through start/done, with a per-tile watchdog.
// Latency: ISSUE one cycle after accept; tile period = engine latency + 1;
//          job_done_o one cycle after the last done (or after the watchdog fires).
// Backpressure: job_ready_o is high only in IDLE, so one job is in flight at a time.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   job_valid_i/job_ready_o   job request handshake; job_tiles_i sampled on accept
//   abort_i                   cancel the job in flight (returns to IDLE, no job_done_o)
//   start_o / done_i          one-cycle engine start pulse / engine completion pulse
//   tile_idx_o                0-based index of the tile in flight
//   busy_o, job_done_o        not-IDLE indicator, one-cycle end-of-job pulse
//   err_o                     sticky timeout flag, cleared on the next accept
module tile_sequencer #(
  parameter int COUNT_NUM     = 16,
  parameter int TIMEOUT_SLACK = 4,
  parameter int TILE_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid_i,
  input  logic [TILE_W-1:0] job_tiles_i,
  output logic              job_ready_o,
  input  logic              abort_i,
  output logic              start_o,
  input  logic              done_i,
  output logic [TILE_W-1:0] tile_idx_o,
  output logic              busy_o,
  output logic              job_done_o,
  output logic              err_o
);

  localparam int LIMIT = COUNT_NUM + TIMEOUT_SLACK;
  localparam int WD_W  = $clog2(LIMIT + 1);
  // Watchdog value seen in the last WAIT cycle that may still accept done_i.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [TILE_W-1:0] tiles_q, tiles_d;
  logic [TILE_W-1:0] idx_q, idx_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_q, err_d;
  // One bit wider so the compare against the tile count cannot wrap.
  logic [TILE_W:0]   idx_next;

  always_comb begin
    state_d  = state_q;
    tiles_d  = tiles_q;
    idx_d    = idx_q;
    wdog_d   = wdog_q;
    err_d    = err_q;
    idx_next = {1'b0, idx_q} + (TILE_W+1)'(1);

    if (abort_i && (state_q != S_IDLE)) begin
      // Cancel wins over done/timeout; err_o keeps whatever it had.
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (job_valid_i) begin
            tiles_d = job_tiles_i;
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = (job_tiles_i == '0) ? S_FINISH : S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          wdog_d = wdog_q + WD_W'(1);
          if (done_i) begin
            if (idx_next == {1'b0, tiles_q}) begin
              // Last tile: index stays on the final tile through FINISH.
              state_d = S_FINISH;
            end else begin
              idx_d   = idx_next[TILE_W-1:0];
              state_d = S_ISSUE;
            end
          end else if (wdog_q == WD_LAST) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tiles_q <= '0;
      idx_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tiles_q <= tiles_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // All outputs decode from registered state only.
  assign job_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign start_o     = (state_q == S_ISSUE);
  assign job_done_o  = (state_q == S_FINISH);
  assign tile_idx_o  = idx_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_tile_sequencer.sv
module tb_tile_sequencer;

  localparam int COUNT_NUM     = 16;
  localparam int TIMEOUT_SLACK = 4;
  localparam int TILE_W        = 8;
  localparam int L             = COUNT_NUM + TIMEOUT_SLACK;
  localparam int NEVER         = 99;  // engine delay meaning "no done_i at all"

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              job_valid_i = 1'b0;
  logic [TILE_W-1:0] job_tiles_i = '0;
  logic              job_ready_o;
  logic              abort_i = 1'b0;
  logic              start_o;
  logic              done_i = 1'b0;
  logic [TILE_W-1:0] tile_idx_o;
  logic              busy_o;
  logic              job_done_o;
  logic              err_o;

  int total = 0;
  int bad   = 0;
  int dly[16];     // per-tile engine latency (start cycle to done cycle)
  bit last_err;
  int last_idx;

  tile_sequencer #(
    .COUNT_NUM(COUNT_NUM),
    .TIMEOUT_SLACK(TIMEOUT_SLACK),
    .TILE_W(TILE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .job_valid_i(job_valid_i),
    .job_tiles_i(job_tiles_i),
    .job_ready_o(job_ready_o),
    .abort_i(abort_i),
    .start_o(start_o),
    .done_i(done_i),
    .tile_idx_o(tile_idx_o),
    .busy_o(busy_o),
    .job_done_o(job_done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Runs one job from the IDLE cycle in which it is offered. Times are counted
  // in cycles after the accept edge. The reference is a timeline: start times
  // follow from engine latencies, the job ends one cycle after the last done,
  // or L+1 cycles after a start that never gets a done. Ends in the IDLE cycle
  // following job_done_o.
  task automatic run_job(input int n, input bit keep_valid, input int next_n);
    int s[16];
    int issued;
    int done_t;
    bit e;
    int t;
    int exp_idx;
    bit exp_start;
    bit drive;
    done_t = 1; e = 1'b0; issued = 0; t = 1; exp_idx = 0;
    for (int i = 0; i < n; i++) begin
      s[i]   = t;
      issued = i + 1;
      if (dly[i] > L) begin
        done_t = t + L + 1;
        e      = 1'b1;
        break;
      end
      t      = t + dly[i] + 1;
      done_t = t;
    end

    job_valid_i = 1'b1;
    job_tiles_i = TILE_W'(n);
    @(posedge clk); #1;
    abort_i = 1'b0;
    if (keep_valid) job_tiles_i = TILE_W'(next_n);
    else job_valid_i = 1'b0;

    for (t = 1; t <= done_t + 1; t++) begin
      exp_start = 1'b0;
      exp_idx   = 0;
      for (int i = 0; i < issued; i++) begin
        if (s[i] == t) exp_start = 1'b1;
        if (s[i] <= t) exp_idx = i;
      end
      total++;
      if (start_o !== exp_start) begin
        bad++; $display("FAIL job start_o n=%0d t=%0d got=%0b want=%0b", n, t, start_o, exp_start);
      end
      total++;
      if (tile_idx_o !== TILE_W'(exp_idx)) begin
        bad++; $display("FAIL job tile_idx_o n=%0d t=%0d got=%0d want=%0d", n, t, tile_idx_o, exp_idx);
      end
      total++;
      if (job_done_o !== (t == done_t)) begin
        bad++; $display("FAIL job job_done_o n=%0d t=%0d got=%0b want=%0b", n, t, job_done_o, (t == done_t));
      end
      total++;
      if (job_ready_o !== (t > done_t) || busy_o !== (t <= done_t)) begin
        bad++; $display("FAIL job ready/busy n=%0d t=%0d got=%0b/%0b want=%0b/%0b",
                        n, t, job_ready_o, busy_o, (t > done_t), (t <= done_t));
      end
      total++;
      if (err_o !== ((t >= done_t) ? e : 1'b0)) begin
        bad++; $display("FAIL job err_o n=%0d t=%0d got=%0b want=%0b", n, t, err_o, ((t >= done_t) ? e : 1'b0));
      end
      // Engine model, plus stray done_i in ISSUE/FINISH cycles that must be ignored.
      drive = 1'b0;
      for (int i = 0; i < issued; i++)
        if (dly[i] <= L && s[i] + dly[i] == t) drive = 1'b1;
      if (!drive && (exp_start || t == done_t)) drive = 1'($urandom_range(0, 1));
      done_i = drive;
      if (t <= done_t) begin
        @(posedge clk); #1;
      end
    end
    done_i   = 1'b0;
    last_err = e;
    last_idx = exp_idx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (job_ready_o !== 1'b1 || busy_o !== 1'b0 || start_o !== 1'b0 || job_done_o !== 1'b0 ||
        err_o !== 1'b0 || tile_idx_o !== '0) begin
      bad++; $display("FAIL reset outputs got rdy=%0b busy=%0b st=%0b jd=%0b err=%0b idx=%0d want 1 0 0 0 0 0",
                      job_ready_o, busy_o, start_o, job_done_o, err_o, tile_idx_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_three_tiles();
    for (int i = 0; i < 3; i++) dly[i] = COUNT_NUM;
    run_job(3, 1'b0, 0);
  endtask

  task automatic test_zero_tiles();
    run_job(0, 1'b0, 0);
  endtask

  task automatic test_timeout();
    dly[0] = NEVER;
    dly[1] = COUNT_NUM;
    run_job(2, 1'b0, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (err_o !== 1'b1 || tile_idx_o !== '0 || job_ready_o !== 1'b1) begin
        bad++; $display("FAIL timeout hold c=%0d got err=%0b idx=%0d rdy=%0b want 1 0 1",
                        c, err_o, tile_idx_o, job_ready_o);
      end
    end
  endtask

  task automatic test_done_at_limit();
    dly[0] = L;
    dly[1] = $urandom_range(1, L);
    run_job(2, 1'b0, 0);
    // One past the limit must time out.
    dly[0] = L + 1;
    run_job(1, 1'b0, 0);
  endtask

  task automatic test_abort();
    int ta;
    bit exp_start;
    job_valid_i = 1'b1;
    job_tiles_i = TILE_W'(4);
    @(posedge clk); #1;
    job_valid_i = 1'b0;
    ta = 19 + $urandom_range(0, 15);
    for (int t = 1; t <= ta; t++) begin
      exp_start = (t == 1 || t == 18);
      total++;
      if (start_o !== exp_start || tile_idx_o !== TILE_W'(t >= 18 ? 1 : 0) || busy_o !== 1'b1) begin
        bad++; $display("FAIL abort pre t=%0d got st=%0b idx=%0d busy=%0b want %0b %0d 1",
                        t, start_o, tile_idx_o, busy_o, exp_start, (t >= 18 ? 1 : 0));
      end
      done_i  = (t == 17);
      abort_i = (t == ta);
      @(posedge clk); #1;
    end
    done_i  = 1'b0;
    abort_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (job_ready_o !== 1'b1 || busy_o !== 1'b0 || job_done_o !== 1'b0 || start_o !== 1'b0 ||
          tile_idx_o !== '0 || err_o !== 1'b0) begin
        bad++; $display("FAIL abort post c=%0d got rdy=%0b busy=%0b jd=%0b st=%0b idx=%0d err=%0b want 1 0 0 0 0 0",
                        c, job_ready_o, busy_o, job_done_o, start_o, tile_idx_o, err_o);
      end
      @(posedge clk); #1;
    end
    dly[0] = COUNT_NUM;
    run_job(1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    // First job times out with job_valid_i held; the next is taken on the
    // first IDLE cycle, alongside an abort_i that must not block it.
    dly[0] = NEVER;
    run_job(2, 1'b1, 1);
    abort_i = 1'b1;
    dly[0]  = $urandom_range(1, L);
    run_job(1, 1'b0, 0);

    // Reset in the middle of tile 1.
    job_valid_i = 1'b1;
    job_tiles_i = TILE_W'(3);
    @(posedge clk); #1;
    job_valid_i = 1'b0;
    for (int t = 1; t < 10; t++) begin
      done_i = (t == 5);
      @(posedge clk); #1;
    end
    done_i = 1'b0;
    total++;
    if (tile_idx_o !== TILE_W'(1) || busy_o !== 1'b1) begin
      bad++; $display("FAIL midjob before rst got idx=%0d busy=%0b want 1 1", tile_idx_o, busy_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (job_ready_o !== 1'b1 || busy_o !== 1'b0 || start_o !== 1'b0 || job_done_o !== 1'b0 ||
        err_o !== 1'b0 || tile_idx_o !== '0) begin
      bad++; $display("FAIL midjob rst got rdy=%0b busy=%0b st=%0b jd=%0b err=%0b idx=%0d want 1 0 0 0 0 0",
                      job_ready_o, busy_o, start_o, job_done_o, err_o, tile_idx_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) dly[i] = NEVER;
        else if ($urandom_range(0, 3) == 0) dly[i] = L;
        else dly[i] = $urandom_range(1, L);
      end
      run_job(n, 1'b0, 0);
      for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_tiles();
    test_zero_tiles();
    test_timeout();
    test_done_at_limit();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
